alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8-bit combinational ALU, with a valid/ready handshake on input and output.
- Adds status flags (zero, negative, carry, overflow, illegal-op) and a sideband tag that travels with each operation.
- Fixed 2-stage pipeline: operand register stage, then compute/result register stage.
- Sits between an instruction/command issuer and a result consumer; tolerates consumer backpressure without losing or duplicating operations.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_core.sv | 96 +++++++++
 rtl/alu_pipe.sv | 99 +++++++++
 tb/tb_alu_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag layout for the pipelined ALU.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package alu_pkg;

    // Opcode encoding; codes from NUM_OPS upward are illegal
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SHL = 4'd2,
        ALU_SRA = 4'd3,
        ALU_SRL = 4'd4,
        ALU_AND = 4'd5,
        ALU_OR  = 4'd6,
        ALU_XOR = 4'd7,
        ALU_EQ  = 4'd8
    } alu_op_e;

    // Bit order matches the out_flags port: {illegal, overflow, carry, negative, zero}
    typedef struct packed {
        logic illegal;
        logic overflow;
        logic carry;
        logic negative;
        logic zero;
    } alu_flags_t;

    localparam int NUM_OPS = 9;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and status flags from op, a, b.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline decides when to capture.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] sh;
    logic               big;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     srl_ext;
    logic [WIDTH:0]     sra_ext;
    logic               carry;
    logic               overflow;
    logic               illegal;

    // Shift amount is the low B bits; any higher B bit means "shifted past the word"
    assign sh  = b[SHAMT_W-1:0];
    assign big = |b[WIDTH-1:SHAMT_W];

    // One extra bit on each arithmetic/shift vector captures carry, borrow or
    // the last bit shifted out; it reads as 0 when sh is 0
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign shl_ext = {1'b0, a} << sh;
    assign srl_ext = {a, 1'b0} >> sh;
    assign sra_ext = $signed({a, 1'b0}) >>> sh;

    // Opcode decode; when the shift runs past the word the last bit out is the fill bit
    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SHL: begin
                if (!big) begin
                    result = shl_ext[WIDTH-1:0];
                    carry  = shl_ext[WIDTH];
                end
            end
            ALU_SRA: begin
                if (big) begin
                    result = {WIDTH{a[WIDTH-1]}};
                    carry  = a[WIDTH-1];
                end else begin
                    result = sra_ext[WIDTH:1];
                    carry  = sra_ext[0];
                end
            end
            ALU_SRL: begin
                if (!big) begin
                    result = srl_ext[WIDTH:1];
                    carry  = srl_ext[0];
                end
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: illegal = 1'b1;
        endcase
    end

    // Illegal ops leave result at 0, so zero=1 and negative=0 fall out naturally
    assign flags = '{
        illegal:  illegal,
        overflow: overflow,
        carry:    carry,
        negative: result[WIDTH-1],
        zero:     (result == '0)
    };

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with sideband tag: operand register, then compute/result register.
// Latency: 2 cycles from input transfer to out_valid; 1 op/cycle sustained.
// Backpressure: out_ready low freezes the result stage; in_ready drops only when both stages are full.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags
);

    // Operand stage
    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    // Result stage
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    alu_flags_t       s2_flags;
    logic [TAG_W-1:0] s2_tag;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    // A stage may load when it is empty or its contents move on this cycle
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = rst_n && s1_load;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (core_result),
        .flags  (core_flags)
    );

    // Operand stage capture; data only moves when a real op arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
        end
    end

    // Result stage capture; holds steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
            s2_tag    <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= core_result;
                s2_flags  <= core_flags;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;
    assign out_flags  = s2_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8, TAG_W=4): directed ops, backpressure, throughput, reset.
// Latency: expects results two edges after acceptance.
// Backpressure: drives out_ready low mid-stream and checks stability and ordering.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_tag;
    logic [4:0] out_flags;

    typedef struct {
        logic [7:0] r;
        logic [4:0] f;
        logic [3:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_out    = 0;
    bit   mon_took = 1'b0;

    alu_pipe #(
        .WIDTH (8),
        .TAG_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference model in plain integer arithmetic; returns {result[7:0], flags[4:0]}
    // with flags = {illegal, overflow, carry, negative, zero}. Shifting by B >= 8 pushes
    // the whole word out, so the last bit out is the fill bit (0, or the sign for SRA).
    function automatic logic [12:0] ref_model(input int op, input int a, input int b);
        int r, c, v, sa, sb, full;
        r = 0; c = 0; v = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin
                full = a + b; r = full & 255; c = int'(full > 255);
                v = int'((sa + sb > 127) || (sa + sb < -128));
            end
            1: begin
                full = a - b; r = full & 255; c = int'(a < b);
                v = int'((sa - sb > 127) || (sa - sb < -128));
            end
            2: begin
                if (b < 8) begin full = a << b; r = full & 255; c = (full >> 8) & 1; end
            end
            3: begin
                if (b >= 8) begin r = (sa < 0) ? 255 : 0; c = int'(sa < 0); end
                else begin
                    r = (sa >>> b) & 255;
                    c = (b == 0) ? 0 : ((sa >>> (b - 1)) & 1);
                end
            end
            4: begin
                if (b < 8) begin r = a >> b; c = (b == 0) ? 0 : ((a >> (b - 1)) & 1); end
            end
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: r = int'(a == b);
            default: return {8'h00, 5'b10001};
        endcase
        return {r[7:0], 1'b0, v[0], c[0], r[7], (r[7:0] == 8'd0)};
    endfunction

    task automatic expect_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] tag);
        logic [12:0] m;
        exp_t        e;
        m     = ref_model(int'(op), int'(a), int'(b));
        e.r   = m[12:5];
        e.f   = m[4:0];
        e.tag = tag;
        exp_q.push_back(e);
        n_acc++;
    endtask

    // Output monitor: every output transfer must match the oldest expected op
    initial forever begin
        exp_t e;
        @(negedge clk);
        mon_took = 1'b0;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_took = 1'b1;
            n_out++;
            check("out.expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out.result", 32'(out_result), 32'(e.r));
                check("out.flags",  32'(out_flags),  32'(e.f));
                check("out.tag",    32'(out_tag),    32'(e.tag));
            end
        end
    end

    // One op into an empty pipeline, result checked against hand-derived constants
    task automatic send_check(input string name, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] tag,
                              input logic [7:0] exp_r, input logic [4:0] exp_f);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        expect_op(op, a, b, tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, ".not_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, ".valid"},  32'(out_valid),  32'd1);
        check({name, ".result"}, 32'(out_result), 32'(exp_r));
        check({name, ".flags"},  32'(out_flags),  32'(exp_f));
        check({name, ".tag"},    32'(out_tag),    32'(tag));
        @(posedge clk); #1;
    endtask

    // Cycle-by-cycle stream with an optional out_ready stall window.
    // in_ready is predicted from a 2-entry buffer that can pass through on a transfer.
    task automatic stream(input int nops, input int st_from, input int st_len, input bit rnd,
                          output int nvalid, output int span, output int low_cycles);
        int         sent = 0, cyc = 0, first = -1, last = -1, occ;
        bit         need_new = 1'b1, prev_stall = 1'b0, exp_rdy;
        logic [7:0] prev_r;
        logic [4:0] prev_f;
        logic [3:0] prev_t;
        nvalid = 0; low_cycles = 0;
        while ((sent < nops || exp_q.size() != 0) && cyc < 300) begin
            out_ready = !(cyc >= st_from && cyc < st_from + st_len);
            if (sent < nops && need_new) begin
                need_new = 1'b0;
                in_valid = 1'b1;
                if (rnd) begin
                    in_op  = 4'($urandom_range(0, 15));
                    in_a   = 8'($urandom_range(0, 255));
                    in_b   = (in_op inside {[2:4]} && $urandom_range(0, 3) != 0)
                             ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
                    in_tag = 4'($urandom_range(0, 15));
                end else begin
                    in_op  = 4'(ALU_ADD);
                    in_a   = 8'(sent * 16 + 1);
                    in_b   = 8'(sent);
                    in_tag = 4'(sent);
                end
            end else if (sent >= nops) begin
                in_valid = 1'b0;
            end
            @(negedge clk); #1;
            occ     = n_acc - n_out + int'(mon_took);
            exp_rdy = !(occ >= 2 && !out_ready);
            check("stream.in_ready", 32'(in_ready), 32'(exp_rdy));
            if (!in_ready) low_cycles++;
            if (prev_stall) begin
                check("stall.valid",  32'(out_valid),  32'd1);
                check("stall.result", 32'(out_result), 32'(prev_r));
                check("stall.flags",  32'(out_flags),  32'(prev_f));
                check("stall.tag",    32'(out_tag),    32'(prev_t));
            end
            if (out_valid) begin
                nvalid++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_r = out_result; prev_f = out_flags; prev_t = out_tag;
            if (in_valid && in_ready) begin
                expect_op(in_op, in_a, in_b, in_tag);
                sent++;
                need_new = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream.all_sent", 32'(sent), 32'(nops));
        check("stream.drained",  32'(exp_q.size()), 32'd0);
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion by 200000, required finish");
        $fatal(1);
    end

    initial begin
        int nvalid, span, low, base;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid",  32'(out_valid),  32'd0);
        check("rst.in_ready",   32'(in_ready),   32'd0);
        check("rst.out_result", 32'(out_result), 32'd0);
        check("rst.out_tag",    32'(out_tag),    32'd0);
        check("rst.out_flags",  32'(out_flags),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.in_ready",  32'(in_ready),  32'd1);
        check("rel.out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Directed ops: flags are {illegal, overflow, carry, negative, zero}
        send_check("add_wrap",  4'(ALU_ADD), 8'hFF, 8'h01, 4'd3,  8'h00, 5'b00101);
        send_check("sub_ovf",   4'(ALU_SUB), 8'h80, 8'h01, 4'd7,  8'h7F, 5'b01000);
        send_check("eq_true",   4'(ALU_EQ),  8'h5A, 8'h5A, 4'd1,  8'h01, 5'b00000);
        send_check("sra_2",     4'(ALU_SRA), 8'h90, 8'h02, 4'd9,  8'hE4, 5'b00010);
        send_check("sra_big",   4'(ALU_SRA), 8'h90, 8'h09, 4'd10, 8'hFF, 5'b00110);
        send_check("shl_1",     4'(ALU_SHL), 8'h81, 8'h01, 4'd12, 8'h02, 5'b00100);
        send_check("srl_3",     4'(ALU_SRL), 8'h0C, 8'h03, 4'd2,  8'h01, 5'b00100);
        send_check("illegal_c", 4'hC,        8'h33, 8'h44, 4'd15, 8'h00, 5'b10001);

        // Backpressure: tags 0..5, out_ready low for cycles 2..5
        base = n_out;
        stream(6, 2, 4, 1'b0, nvalid, span, low);
        check("bp.delivered",       32'(n_out - base), 32'd6);
        check("bp.in_ready_low",    32'(low),          32'd4);

        // Throughput: 20 random ops, no stall
        base = n_out;
        stream(20, -1, 0, 1'b1, nvalid, span, low);
        check("tp.delivered",       32'(n_out - base), 32'd20);
        check("tp.valid_cycles",    32'(nvalid),       32'd20);
        check("tp.consecutive",     32'(span),         32'd20);
        check("tp.in_ready_low",    32'(low),          32'd0);

        // Reset with two ops in flight; neither may ever appear
        in_valid = 1'b1; in_op = 4'(ALU_ADD); in_a = 8'h11; in_b = 8'h22; in_tag = 4'd4;
        @(posedge clk); #1;
        in_op = 4'(ALU_SUB); in_tag = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid.inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid.rst_out_valid", 32'(out_valid), 32'd0);
        check("mid.rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid.rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("mid.no_stale", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send_check("post_rst", 4'(ALU_XOR), 8'hF0, 8'h3C, 4'd6, 8'hCC, 5'b00010);
        check("final.queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
